// File: rtl/input_handshake.sv
// Input-port front end: synchronises switches and push-button, debounces the button.
// Build option INPUT_HS_SW_LATCH_EN: capture switches only when a press is accepted.
module input_handshake #(
    parameter int BUS_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_WIDTH      = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [BUS_WIDTH-1:0] sw_raw,
    input  logic                 btn_raw,
    output logic [BUS_WIDTH-1:0] in_port,
    output logic                 ready_in,
    output logic                 busy
);

    // state      | meaning
    // IDLE       | button released and accepted as released
    // PRESS_DB   | btn_s high, waiting for a stable press window
    // HELD       | press accepted, ready_in high
    // RELEASE_DB | btn_s low, waiting for a stable release window
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 btn_s1;
    logic                 btn_s;
    logic [BUS_WIDTH-1:0] sw_s1;
    logic [BUS_WIDTH-1:0] sw_s;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 ready_nxt;
    logic                 busy_nxt;
    logic                 press_accept;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            btn_s1 <= 1'b0;
            btn_s  <= 1'b0;
            sw_s1  <= '0;
            sw_s   <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s  <= btn_s1;
            sw_s1  <= sw_raw;
            sw_s   <= sw_s1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_in <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready_in <= ready_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ready_nxt    = ready_in;
        press_accept = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt    = HELD;
                    ready_nxt    = 1'b1;
                    press_accept = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_DB;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_DB: begin
                if (btn_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                ready_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt == PRESS_DB) || (state_nxt == RELEASE_DB);
    end

`ifdef INPUT_HS_SW_LATCH_EN
    // Snapshot switches on the same edge that ready_in rises.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            in_port <= '0;
        end else if (press_accept) begin
            in_port <= sw_s;
        end
    end
`else
    // Transparent: second sync stage drives the port directly (still a flop output).
    assign in_port = sw_s;
`endif

endmodule

// File: tb/tb_input_handshake.sv
// Self-checking bench for input_handshake: directed scenarios plus random bouncing
// button and switches, compared against a run-length debounce model.
module tb_input_handshake;

    localparam int BW = 8;
    localparam int D  = 4;

    logic          clk;
    logic          n_reset;
    logic [BW-1:0] sw_raw;
    logic          btn_raw;
    logic [BW-1:0] in_port;
    logic          ready_in;
    logic          busy;

    int tests;
    int fails;

    // model: raw samples delayed two edges, and the length of the current run
    // of samples that disagree with the accepted level
    logic          b_d1, b_d2;
    logic [BW-1:0] w_d1, w_d2;
    int            streak;
    logic          m_ready;
    logic          m_busy;
    logic [BW-1:0] m_latch;
    logic [BW-1:0] m_in;

    input_handshake #(.BUS_WIDTH(BW), .DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .sw_raw   (sw_raw),
        .btn_raw  (btn_raw),
        .in_port  (in_port),
        .ready_in (ready_in),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef INPUT_HS_SW_LATCH_EN
    always_comb m_in = m_latch;
`else
    always_comb m_in = w_d2;
`endif

    task automatic model_reset();
        b_d1 = 1'b0; b_d2 = 1'b0;
        w_d1 = '0;   w_d2 = '0;
        streak  = 0;
        m_ready = 1'b0;
        m_busy  = 1'b0;
        m_latch = '0;
    endtask

    // one clock edge; model sees the same inputs the DUT sampled, outputs settle by +1
    task automatic tick();
        logic          seen;
        logic [BW-1:0] sw_seen;
        @(posedge clk);
        if (n_reset) begin
            seen    = b_d2;
            sw_seen = w_d2;
            b_d2 = b_d1; b_d1 = btn_raw;
            w_d2 = w_d1; w_d1 = sw_raw;
            if (seen != m_ready) begin
                streak++;
                if (streak == D + 1) begin
                    m_ready = seen;
                    streak  = 0;
                    if (seen) m_latch = sw_seen;
                end
            end else begin
                streak = 0;
            end
            m_busy = (streak != 0);
        end
        #1;
    endtask

    task automatic test_reset();
        btn_raw = 1'b1;
        sw_raw  = 8'hFF;
        for (int i = 0; i < 10; i++) tick();
        #3;
        n_reset = 1'b0;
        model_reset();
        #1;
        tests++;
        if (in_port !== 8'h00 || ready_in !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: in_port=%h ready_in=%0b busy=%0b, expected 00 0 0",
                     in_port, ready_in, busy);
        end
        btn_raw = 1'b0;
        sw_raw  = 8'h00;
        tick();
        tick();
        n_reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (in_port !== 8'h00 || ready_in !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: in_port=%h ready_in=%0b busy=%0b, expected 00 0 0",
                     in_port, ready_in, busy);
        end
    endtask

    task automatic test_clean_press();
        logic exp_r, exp_b;
        btn_raw = 1'b1;
        for (int e = 1; e <= D + 3; e++) begin
            tick();
            exp_r = (e >= D + 3);
            exp_b = (e >= 3) && (e <= D + 2);
            tests++;
            if (ready_in !== exp_r || busy !== exp_b) begin
                fails++;
                $display("FAIL clean_press edge %0d: ready_in=%0b busy=%0b, expected %0b %0b",
                         e, ready_in, busy, exp_r, exp_b);
            end
        end
        btn_raw = 1'b0;
        for (int i = 0; i < D + 4; i++) tick();
        tests++;
        if (ready_in !== 1'b0 || ready_in !== m_ready) begin
            fails++;
            $display("FAIL clean_release: ready_in=%0b, expected 0", ready_in);
        end
    endtask

    task automatic test_bounce_reject();
        logic exp_r;
        int   bad = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); if (ready_in !== 1'b0) bad++; end
        btn_raw = 1'b0;
        tick();
        if (ready_in !== 1'b0) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bounce_pulse: ready_in went high %0d times during bounce, expected 0", bad);
        end
        btn_raw = 1'b1;
        for (int e = 1; e <= D + 3; e++) begin
            tick();
            exp_r = (e >= D + 3);
            tests++;
            if (ready_in !== exp_r || ready_in !== m_ready) begin
                fails++;
                $display("FAIL bounce_final edge %0d: ready_in=%0b, expected %0b", e, ready_in, exp_r);
            end
        end
    endtask

    task automatic test_release_debounce();
        logic exp_r;
        int   bad = 0;
        btn_raw = 1'b0;
        tick(); if (ready_in !== 1'b1) bad++;
        tick(); if (ready_in !== 1'b1) bad++;
        btn_raw = 1'b1;
        tick(); if (ready_in !== 1'b1) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL release_bounce: ready_in dropped %0d times, expected 0", bad);
        end
        btn_raw = 1'b0;
        for (int e = 1; e <= D + 3; e++) begin
            tick();
            exp_r = (e < D + 3);
            tests++;
            if (ready_in !== exp_r || busy !== m_busy) begin
                fails++;
                $display("FAIL release_final edge %0d: ready_in=%0b busy=%0b, expected %0b %0b",
                         e, ready_in, busy, exp_r, m_busy);
            end
        end
    endtask

    task automatic test_switch();
`ifdef INPUT_HS_SW_LATCH_EN
        sw_raw  = 8'h5A;
        btn_raw = 1'b1;
        for (int i = 0; i < D + 4; i++) tick();
        sw_raw = 8'hC3;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (in_port !== 8'h5A) begin
            fails++;
            $display("FAIL latch_held: in_port=%h, expected 5a", in_port);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < D + 4; i++) tick();
        tests++;
        if (in_port !== 8'h5A) begin
            fails++;
            $display("FAIL latch_released: in_port=%h, expected 5a", in_port);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < D + 4; i++) tick();
        tests++;
        if (in_port !== 8'hC3 || ready_in !== 1'b1) begin
            fails++;
            $display("FAIL latch_repress: in_port=%h ready_in=%0b, expected c3 1", in_port, ready_in);
        end
`else
        sw_raw = 8'h5A;
        for (int i = 0; i < 3; i++) tick();
        sw_raw = 8'hC3;
        tick();
        tests++;
        if (in_port !== 8'h5A) begin
            fails++;
            $display("FAIL transparent_edge1: in_port=%h, expected 5a", in_port);
        end
        tick();
        tests++;
        if (in_port !== 8'hC3 || ready_in !== 1'b0) begin
            fails++;
            $display("FAIL transparent_edge2: in_port=%h ready_in=%0b, expected c3 0", in_port, ready_in);
        end
`endif
        btn_raw = 1'b0;
        for (int i = 0; i < D + 4; i++) tick();
    endtask

    task automatic test_reset_mid_hold();
        logic exp_r;
        btn_raw = 1'b1;
        for (int i = 0; i < D + 4; i++) tick();
        tests++;
        if (ready_in !== 1'b1) begin
            fails++;
            $display("FAIL hold_before_reset: ready_in=%0b, expected 1", ready_in);
        end
        n_reset = 1'b0;
        model_reset();
        #1;
        tests++;
        if (ready_in !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_reset_async: ready_in=%0b busy=%0b, expected 0 0", ready_in, busy);
        end
        tick();
        tick();
        n_reset = 1'b1;
        for (int e = 1; e <= D + 3; e++) begin
            tick();
            exp_r = (e >= D + 3);
            tests++;
            if (ready_in !== exp_r) begin
                fails++;
                $display("FAIL rerise_after_reset edge %0d: ready_in=%0b, expected %0b", e, ready_in, exp_r);
            end
        end
        btn_raw = 1'b0;
        for (int i = 0; i < D + 4; i++) tick();
    endtask

    task automatic test_random();
        int seg;
        int bad = 0;
        int toggles = 0;
        logic prev;
        prev = ready_in;
        for (int c = 0; c < 600; ) begin
            btn_raw = ~btn_raw;
            seg = ($urandom_range(0, 3) == 0) ? $urandom_range(D + 1, 12) : $urandom_range(1, D + 2);
            for (int k = 0; k < seg; k++) begin
                if ($urandom_range(0, 7) == 0) sw_raw = BW'($urandom);
                tick();
                c++;
                tests++;
                if (ready_in !== m_ready || busy !== m_busy || in_port !== m_in) begin
                    fails++;
                    if (bad < 10)
                        $display("FAIL random cycle %0d: ready_in=%0b busy=%0b in_port=%h, expected %0b %0b %h",
                                 c, ready_in, busy, in_port, m_ready, m_busy, m_in);
                    bad++;
                end
                if (ready_in !== prev) toggles++;
                prev = ready_in;
            end
        end
        tests++;
        if (toggles == 0) begin
            fails++;
            $display("FAIL random_activity: ready_in toggles=%0d, expected >0", toggles);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < D + 4; i++) tick();
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        n_reset = 1'b0;
        btn_raw = 1'b0;
        sw_raw  = '0;
        model_reset();
        #12;
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_release_debounce();
        btn_raw = 1'b0;
        for (int i = 0; i < D + 4; i++) tick();
        test_switch();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
